// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI APB register slave: register addresses,
// control/status bit positions, reset values and the SR packing helper.
// -----------------------------------------------------------------------------
package spi_pkg;

    // Register addresses
    localparam logic [2:0] ADDR_CR1  = 3'd0;
    localparam logic [2:0] ADDR_CR2  = 3'd1;
    localparam logic [2:0] ADDR_BR   = 3'd2;
    localparam logic [2:0] ADDR_SR   = 3'd3;
    localparam logic [2:0] ADDR_LVL  = 3'd4;
    localparam logic [2:0] ADDR_DR   = 3'd5;
    localparam logic [2:0] ADDR_ICR  = 3'd6;
    localparam logic [2:0] ADDR_RSVD = 3'd7;

    // CR1 bit indices
    localparam int CR1_SPIE  = 7;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_LSBFE = 0;

    // CR2 bit indices
    localparam int CR2_OVRIE   = 2;
    localparam int CR2_RXFLUSH = 1;
    localparam int CR2_TXFLUSH = 0;

    // SR bit indices
    localparam int SR_RXNE  = 7;
    localparam int SR_RXF   = 6;
    localparam int SR_TXE   = 5;
    localparam int SR_TXF   = 4;
    localparam int SR_OVR   = 3;

    // ICR bit index
    localparam int ICR_OVRC = 3;

    // Reset values
    localparam logic [7:0] CR1_RST = 8'h04;
    localparam logic [7:0] CR2_RST = 8'h00;
    localparam logic [7:0] BR_RST  = 8'h00;

    // Assemble the status byte from the individual flags
    function automatic logic [7:0] sr_pack(input logic rx_ne, input logic rx_full,
                                           input logic tx_empty, input logic tx_full,
                                           input logic ovr);
        logic [7:0] v;
        v           = 8'h00;
        v[SR_RXNE]  = rx_ne;
        v[SR_RXF]   = rx_full;
        v[SR_TXE]   = tx_empty;
        v[SR_TXF]   = tx_full;
        v[SR_OVR]   = ovr;
        return v;
    endfunction

endpackage

// File: rtl/spi_apb_fifo_regs_if.sv
// -----------------------------------------------------------------------------
// spi_apb_fifo_regs_if
// APB3 bus bundle for the SPI register slave.
//   master: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave : the reverse
// -----------------------------------------------------------------------------
interface spi_apb_fifo_regs_if #(
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [2:0]        PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// -----------------------------------------------------------------------------
// spi_sync_fifo
// Single-clock FIFO with flush. A push into a full FIFO is accepted when a pop
// happens on the same edge. Flush has priority over push and pop.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and data
//   pop          : read request (head advances)
//   flush        : empty the FIFO on this edge
//   rdata        : head entry (0 when empty)
//   full, empty  : status
//   level        : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module spi_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty = (level_r == LW'(0));
    assign full  = (level_r == LW'(DEPTH));
    assign level = level_r;

    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Head-of-queue read, forced to zero when nothing is stored
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = '0;
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_apb_fifo_regs.sv
// -----------------------------------------------------------------------------
// spi_apb_fifo_regs
// APB register slave for the SPI controller with TX/RX FIFOs behind SPI_DR.
//   PCLK, PRESETn         : clock, asynchronous active-low reset
//   apb                   : APB slave (zero wait state, PSLVERR on bad access)
//   mstr..spe, sppr, spr  : configuration from CR1 and BR
//   tx_data/valid/ready   : TX FIFO head handshake to the shift register
//   rx_data/valid         : received frame, one-cycle pulse
//   spi_irq               : level interrupt
// -----------------------------------------------------------------------------
module spi_apb_fifo_regs
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    spi_apb_fifo_regs_if.slave  apb,
    output logic                mstr,
    output logic                cpol,
    output logic                cpha,
    output logic                lsbfe,
    output logic                spe,
    output logic [2:0]          sppr,
    output logic [2:0]          spr,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                spi_irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        cr1_r;
    logic [7:0]        cr2_r;
    logic [7:0]        br_r;
    logic              ovr_r;

    logic              access_s, wr_s, rd_s, err_s;
    logic              wr_ok_s, rd_ok_s;
    logic              tx_push_s, tx_pop_s, tx_flush_s;
    logic              rx_pop_s, rx_flush_s;
    logic              ovr_set_s, ovr_clr_s;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [LW-1:0]     tx_level_s, rx_level_s;
    logic [DATA_W-1:0] rx_head_s;
    logic [DATA_W-1:0] prdata_s;

    assign access_s = apb.PSEL && apb.PENABLE;
    assign wr_s     = access_s && apb.PWRITE;
    assign rd_s     = access_s && !apb.PWRITE;

    assign tx_valid = cr1_r[CR1_SPE] && !tx_empty_s;
    assign tx_pop_s = tx_valid && tx_ready;

    // Access legality; an erroring access changes no state
    always_comb begin
        err_s = 1'b0;
        case (apb.PADDR)
            ADDR_SR, ADDR_LVL: err_s = apb.PWRITE;
            ADDR_DR:           err_s = apb.PWRITE ? (tx_full_s && !tx_pop_s) : rx_empty_s;
            ADDR_RSVD:         err_s = 1'b1;
            default:           err_s = 1'b0;
        endcase
    end

    assign wr_ok_s    = wr_s && !err_s;
    assign rd_ok_s    = rd_s && !err_s;
    assign tx_push_s  = wr_ok_s && (apb.PADDR == ADDR_DR);
    assign rx_pop_s   = rd_ok_s && (apb.PADDR == ADDR_DR);
    assign tx_flush_s = wr_ok_s && (apb.PADDR == ADDR_CR2) && apb.PWDATA[CR2_TXFLUSH];
    assign rx_flush_s = wr_ok_s && (apb.PADDR == ADDR_CR2) && apb.PWDATA[CR2_RXFLUSH];

    // A frame arriving into a full RX FIFO with no same-cycle read is lost
    assign ovr_set_s = rx_valid && rx_full_s && !rx_pop_s;
    assign ovr_clr_s = wr_ok_s && (apb.PADDR == ADDR_ICR) && apb.PWDATA[ICR_OVRC];

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push_s),
        .wdata (apb.PWDATA),
        .pop   (tx_pop_s),
        .flush (tx_flush_s),
        .rdata (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .level (tx_level_s)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rx_pop_s),
        .flush (rx_flush_s),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .level (rx_level_s)
    );

    // Control register writes; CR2 flush bits are strobes and never stored
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cr1_r <= CR1_RST;
            cr2_r <= CR2_RST;
            br_r  <= BR_RST;
        end else if (wr_ok_s) begin
            case (apb.PADDR)
                ADDR_CR1: cr1_r <= apb.PWDATA[7:0];
                ADDR_CR2: cr2_r <= {apb.PWDATA[7:2], 2'b00};
                ADDR_BR:  br_r  <= apb.PWDATA[7:0];
                default: begin
                    cr1_r <= cr1_r;
                    cr2_r <= cr2_r;
                    br_r  <= br_r;
                end
            endcase
        end else begin
            cr1_r <= cr1_r;
            cr2_r <= cr2_r;
            br_r  <= br_r;
        end
    end

    // Sticky overrun flag; a coincident set beats the clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovr_r <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr_s) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    // Read data mux, zero outside a legal read access
    always_comb begin
        prdata_s = '0;
        if (rd_ok_s) begin
            case (apb.PADDR)
                ADDR_CR1: prdata_s = DATA_W'(cr1_r);
                ADDR_CR2: prdata_s = DATA_W'(cr2_r);
                ADDR_BR:  prdata_s = DATA_W'(br_r);
                ADDR_SR:  prdata_s = DATA_W'(sr_pack(!rx_empty_s, rx_full_s,
                                                     tx_empty_s, tx_full_s, ovr_r));
                ADDR_LVL: prdata_s = DATA_W'({4'(tx_level_s), 4'(rx_level_s)});
                ADDR_DR:  prdata_s = rx_head_s;
                default:  prdata_s = '0;
            endcase
        end else begin
            prdata_s = '0;
        end
    end

    assign apb.PRDATA  = prdata_s;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access_s && err_s;

    assign mstr  = cr1_r[CR1_MSTR];
    assign cpol  = cr1_r[CR1_CPOL];
    assign cpha  = cr1_r[CR1_CPHA];
    assign lsbfe = cr1_r[CR1_LSBFE];
    assign spe   = cr1_r[CR1_SPE];
    assign sppr  = br_r[6:4];
    assign spr   = br_r[2:0];

    assign spi_irq = (cr1_r[CR1_SPIE]  && !rx_empty_s) ||
                     (cr1_r[CR1_SPTIE] && tx_empty_s)  ||
                     (cr2_r[CR2_OVRIE] && ovr_r);

endmodule

// File: tb/tb_spi_apb_fifo_regs.sv
// -----------------------------------------------------------------------------
// tb_spi_apb_fifo_regs
// Directed bench for spi_apb_fifo_regs with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_spi_apb_fifo_regs;

    logic       pclk;
    logic       presetn;
    logic       mstr, cpol, cpha, lsbfe, spe;
    logic [2:0] sppr, spr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_irq;

    int n_checks = 0;
    int n_pass   = 0;

    spi_apb_fifo_regs_if #(.DATA_W(8)) apb ();

    spi_apb_fifo_regs #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .PCLK     (pclk),
        .PRESETn  (presetn),
        .apb      (apb),
        .mstr     (mstr),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsbfe    (lsbfe),
        .spe      (spe),
        .sppr     (sppr),
        .spr      (spr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .spi_irq  (spi_irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One APB transfer; rxp/txr raise rx_valid/tx_ready for the access cycle only
    task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                            input logic rxp, input logic txr,
                            output logic [7:0] rdat, output logic err);
        @(negedge pclk);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        @(negedge pclk);
        apb.PENABLE = 1'b1;
        if (rxp) rx_valid = 1'b1;
        if (txr) tx_ready = 1'b1;
        #1;
        rdat = apb.PRDATA;
        err  = apb.PSLVERR;
        @(negedge pclk);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        rx_valid    = 1'b0;
        if (txr) tx_ready = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [2:0] addr, input logic [7:0] data,
                          input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb_xfer(1'b1, addr, data, 1'b0, 1'b0, d, e);
        check(tag, 16'(e), 16'(exp_err));
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [7:0] exp_d,
                          input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb_xfer(1'b0, addr, 8'h00, 1'b0, 1'b0, d, e);
        check(tag, 16'(d), 16'(exp_d));
        check({tag, "_err"}, 16'(e), 16'(exp_err));
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge pclk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge pclk);
        rx_valid = 1'b0;
    endtask

    task automatic reset_regs_chk(input string tag);
        rd_chk({tag, "_cr1"}, 3'd0, 8'h04, 1'b0);
        rd_chk({tag, "_cr2"}, 3'd1, 8'h00, 1'b0);
        rd_chk({tag, "_br"},  3'd2, 8'h00, 1'b0);
        rd_chk({tag, "_sr"},  3'd3, 8'h20, 1'b0);
        rd_chk({tag, "_lvl"}, 3'd4, 8'h00, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       e;

        presetn     = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 3'd0;
        apb.PWDATA  = 8'h00;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (3) @(negedge pclk);
        #1;
        check("rst_irq",     16'(spi_irq),     16'd0);
        check("rst_txvalid", 16'(tx_valid),    16'd0);
        check("rst_pslverr", 16'(apb.PSLVERR), 16'd0);
        check("rst_cpha",    16'(cpha),        16'd1);
        presetn = 1'b1;

        // Register reset values
        reset_regs_chk("rst");

        // Configuration outputs
        wr_chk("wr_cr1", 3'd0, 8'h5D, 1'b0);
        wr_chk("wr_br",  3'd2, 8'h35, 1'b0);
        #1;
        check("cfg_spe",   16'(spe),   16'd1);
        check("cfg_mstr",  16'(mstr),  16'd1);
        check("cfg_cpol",  16'(cpol),  16'd1);
        check("cfg_lsbfe", 16'(lsbfe), 16'd1);
        check("cfg_sppr",  16'(sppr),  16'd3);
        check("cfg_spr",   16'(spr),   16'd5);

        // Fill TX with the shift register stalled
        for (int i = 0; i < 4; i++) begin
            wr_chk("tx_push", 3'd5, 8'hA1 + 8'(i), 1'b0);
        end
        rd_chk("tx_full_sr",  3'd3, 8'h10, 1'b0);
        rd_chk("tx_full_lvl", 3'd4, 8'h40, 1'b0);
        wr_chk("tx_push_full", 3'd5, 8'hA5, 1'b1);
        rd_chk("tx_full_lvl2", 3'd4, 8'h40, 1'b0);

        // Drain in order
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tx_valid_pop", 16'(tx_valid), 16'd1);
            check("tx_data_pop",  16'(tx_data),  16'(8'hA1 + 8'(i)));
            @(negedge pclk);
        end
        tx_ready = 1'b0;
        #1;
        check("tx_valid_drained", 16'(tx_valid), 16'd0);
        rd_chk("tx_drained_lvl", 3'd4, 8'h00, 1'b0);

        // RX overrun
        for (int i = 0; i < 5; i++) begin
            rx_push(8'h11 + 8'(i));
        end
        rd_chk("rx_ovr_sr",  3'd3, 8'hE8, 1'b0);
        rd_chk("rx_ovr_lvl", 3'd4, 8'h04, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_chk("rx_pop", 3'd5, 8'h11 + 8'(i), 1'b0);
        end
        rd_chk("rx_pop_empty", 3'd5, 8'h00, 1'b1);

        // Overrun interrupt and clear
        wr_chk("wr_cr2_ovrie", 3'd1, 8'h04, 1'b0);
        #1;
        check("irq_ovr", 16'(spi_irq), 16'd1);
        wr_chk("icr_clr", 3'd6, 8'h08, 1'b0);
        #1;
        check("irq_ovr_clr", 16'(spi_irq), 16'd0);
        rd_chk("sr_ovr_clr", 3'd3, 8'h20, 1'b0);

        // Overflow coincident with the clear: set wins
        for (int i = 0; i < 4; i++) begin
            rx_push(8'h31 + 8'(i));
        end
        #1;
        check("irq_rx_full_no_ovr", 16'(spi_irq), 16'd0);
        rx_data = 8'h35;
        apb_xfer(1'b1, 3'd6, 8'h08, 1'b1, 1'b0, d, e);
        check("icr_coinc_err", 16'(e), 16'd0);
        #1;
        check("irq_coinc", 16'(spi_irq), 16'd1);
        rd_chk("sr_coinc", 3'd3, 8'hE8, 1'b0);

        // RX flush keeps ovr
        wr_chk("rx_flush", 3'd1, 8'h06, 1'b0);
        rd_chk("sr_rx_flush", 3'd3, 8'h28, 1'b0);
        rd_chk("cr2_after_flush", 3'd1, 8'h04, 1'b0);
        wr_chk("icr_clr2", 3'd6, 8'h08, 1'b0);
        rd_chk("sr_ovr_clr2", 3'd3, 8'h20, 1'b0);

        // Push into full TX with a same-cycle pop
        for (int i = 0; i < 4; i++) begin
            wr_chk("tx_push_b", 3'd5, 8'hB1 + 8'(i), 1'b0);
        end
        apb_xfer(1'b1, 3'd5, 8'hB5, 1'b0, 1'b1, d, e);
        check("tx_push_pop_err", 16'(e), 16'd0);
        #1;
        check("tx_head_after_pop", 16'(tx_data), 16'hB2);
        rx_push(8'h21);
        rx_push(8'h22);
        rd_chk("lvl_before_flush", 3'd4, 8'h42, 1'b0);

        // Flush both
        wr_chk("flush_both", 3'd1, 8'h03, 1'b0);
        #1;
        check("flush_txvalid", 16'(tx_valid), 16'd0);
        rd_chk("flush_lvl", 3'd4, 8'h00, 1'b0);
        rd_chk("flush_sr",  3'd3, 8'h20, 1'b0);

        // Illegal accesses
        rd_chk("rd_rsvd", 3'd7, 8'h00, 1'b1);
        wr_chk("wr_rsvd", 3'd7, 8'hFF, 1'b1);
        wr_chk("wr_sr",   3'd3, 8'hFF, 1'b1);
        wr_chk("wr_lvl",  3'd4, 8'hFF, 1'b1);
        rd_chk("cr1_kept", 3'd0, 8'h5D, 1'b0);
        rd_chk("br_kept",  3'd2, 8'h35, 1'b0);

        // TX-empty interrupt
        wr_chk("wr_cr1_sptie", 3'd0, 8'h7D, 1'b0);
        #1;
        check("irq_txe", 16'(spi_irq), 16'd1);

        // Reset with FIFOs half full
        wr_chk("tx_push_c1", 3'd5, 8'hC1, 1'b0);
        wr_chk("tx_push_c2", 3'd5, 8'hC2, 1'b0);
        rx_push(8'h41);
        rx_push(8'h42);
        rd_chk("lvl_half", 3'd4, 8'h22, 1'b0);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        check("rst2_txvalid", 16'(tx_valid), 16'd0);
        check("rst2_irq",     16'(spi_irq),  16'd0);
        check("rst2_spe",     16'(spe),      16'd0);
        check("rst2_cpha",    16'(cpha),     16'd1);
        @(negedge pclk);
        presetn = 1'b1;
        reset_regs_chk("rst2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
